// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - dual-core MSI shared-bus arbiter, snoop broadcaster and memory sequencer
// Optional feature macro BUS_C2C_EN: forward dirty snoop data directly to the requester.
module coherence_bus_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req_cmd0,
   input  logic [2:0]        req_cmd1,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic              grant0,
   output logic              grant1,
   output logic [DATA_W-1:0] rdata,
   output logic              snp_rd0,
   output logic              snp_rd1,
   output logic              snp_rdx0,
   output logic              snp_rdx1,
   output logic [ADDR_W-1:0] snp_addr,
   input  logic              snp_ack0,
   input  logic              snp_ack1,
   input  logic              snp_hitm0,
   input  logic              snp_hitm1,
   input  logic [DATA_W-1:0] snp_data0,
   input  logic [DATA_W-1:0] snp_data1,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam logic [2:0] CMD_BUSRD  = 3'd1;
   localparam logic [2:0] CMD_BUSRDX = 3'd2;
   localparam logic [2:0] CMD_INV    = 3'd3;
   localparam logic [2:0] CMD_WB     = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SNOOP, ST_MEMRD, ST_FLUSH, ST_MEMWR, ST_DONE
   } state_t;

   state_t            r_state, w_next;
   logic              r_req, r_rr;
   logic [2:0]        r_cmd;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_fill, r_sdata;

   logic              w_pend0, w_pend1, w_start, w_win, w_ack, w_hitm;
   logic [2:0]        w_win_cmd;
   logic [DATA_W-1:0] w_snp_data;

   // Encodings 5-7 are not requests.
   assign w_pend0    = (req_cmd0 >= CMD_BUSRD) && (req_cmd0 <= CMD_WB);
   assign w_pend1    = (req_cmd1 >= CMD_BUSRD) && (req_cmd1 <= CMD_WB);
   assign w_start    = w_pend0 | w_pend1;
   assign w_win      = (w_pend0 && w_pend1) ? r_rr : w_pend1;
   assign w_win_cmd  = w_win ? req_cmd1 : req_cmd0;
   assign w_ack      = r_req ? snp_ack0  : snp_ack1;
   assign w_hitm     = r_req ? snp_hitm0 : snp_hitm1;
   assign w_snp_data = r_req ? snp_data0 : snp_data1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start) w_next = (w_win_cmd == CMD_WB) ? ST_MEMWR : ST_SNOOP;
         ST_SNOOP: begin
            if (w_ack) begin
               if (r_cmd == CMD_INV) begin
                  w_next = ST_DONE;
               end else if (w_hitm) begin
`ifdef BUS_C2C_EN
                  w_next = (r_cmd == CMD_BUSRDX) ? ST_DONE : ST_FLUSH;
`else
                  w_next = ST_FLUSH;
`endif
               end else begin
                  w_next = ST_MEMRD;
               end
            end
         end
         ST_MEMRD: if (mem_ready) w_next = ST_DONE;
         ST_FLUSH: begin
`ifdef BUS_C2C_EN
            if (mem_ready) w_next = ST_DONE;
`else
            if (mem_ready) w_next = ST_MEMRD;
`endif
         end
         ST_MEMWR: if (mem_ready) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req   <= 1'b0;
         r_rr    <= 1'b0;
         r_cmd   <= 3'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_fill  <= '0;
         r_sdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_req   <= w_win;
                  r_cmd   <= w_win_cmd;
                  r_addr  <= w_win ? req_addr1  : req_addr0;
                  r_wdata <= w_win ? req_wdata1 : req_wdata0;
                  r_fill  <= '0;
               end
            end
            ST_SNOOP: begin
               if (w_ack && (r_cmd != CMD_INV) && w_hitm) begin
                  r_sdata <= w_snp_data;
`ifdef BUS_C2C_EN
                  r_fill  <= w_snp_data;
`endif
               end
            end
            ST_MEMRD: if (mem_ready) r_fill <= mem_rdata;
            ST_DONE:  r_rr <= ~r_req;
            default:  ;
         endcase
      end
   end

   // Every output is a pure decode of the state register and latched fields.
   always_comb begin
      grant0    = 1'b0;
      grant1    = 1'b0;
      rdata     = '0;
      snp_rd0   = 1'b0;
      snp_rd1   = 1'b0;
      snp_rdx0  = 1'b0;
      snp_rdx1  = 1'b0;
      snp_addr  = '0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         ST_SNOOP: begin
            snp_addr = r_addr;
            if (r_cmd == CMD_BUSRD) begin
               snp_rd0 = r_req;
               snp_rd1 = ~r_req;
            end else begin
               snp_rdx0 = r_req;
               snp_rdx1 = ~r_req;
            end
         end
         ST_MEMRD: begin
            mem_ren  = 1'b1;
            mem_addr = r_addr;
         end
         ST_FLUSH: begin
            mem_wen   = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = r_sdata;
         end
         ST_MEMWR: begin
            mem_wen   = 1'b1;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
         end
         ST_DONE: begin
            grant0 = ~r_req;
            grant1 = r_req;
            rdata  = r_fill;
         end
         default: ;
      endcase
   end

endmodule
